// File: rtl/vga_scan_out_if.sv
// rtl/vga_scan_out_if.sv - pixel FIFO read port between the frame-fill FIFO and VGA scan-out
interface vga_scan_out_if;
  logic        fifo_empty;
  logic [23:0] fifo_dout;
  logic        fifo_rd_en;

  // master is the consumer that issues pops; slave is the FIFO
  modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - VGA timing generator that pops one FIFO word per active pixel
module vga_scan_out #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  vga_scan_out_if.master fifo,
  output logic [7:0]     vga_r,
  output logic [7:0]     vga_g,
  output logic [7:0]     vga_b,
  output logic           vga_hsync,
  output logic           vga_vsync,
  output logic           vga_blank,
  output logic           frame_start,
  output logic           underflow
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          tick, active, at_end, in_hs, in_vs;
  logic          pop, starve;
  logic          tick_d, pop_d, hs_d, vs_d, fs_d;

  assign tick   = (div_cnt == DW'(CLK_DIV - 1));
  assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign at_end = (h_cnt == HW'(H_TOTAL - 1)) && (v_cnt == VW'(V_TOTAL - 1));
  assign in_hs  = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign in_vs  = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      if (h_cnt == HW'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_WAIT;
    else      state <= state_nxt;
  end

  // Arming only happens at the frame boundary so a frame is never shown partially
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    starve    = 1'b0;
    case (state)
      S_WAIT: if (tick && at_end && !fifo.fifo_empty) state_nxt = S_RUN;
      S_RUN: begin
        if (tick && active) begin
          if (fifo.fifo_empty) begin
            starve    = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            pop = 1'b1;
          end
        end
      end
    endcase
  end

  assign fifo.fifo_rd_en = pop;

  // Stage 1 holds the tick's timing flags while the FIFO read data lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_d <= 1'b0;
      pop_d  <= 1'b0;
      hs_d   <= ~SYNC_POL;
      vs_d   <= ~SYNC_POL;
      fs_d   <= 1'b0;
    end else begin
      tick_d <= tick;
      if (tick) begin
        pop_d <= pop;
        hs_d  <= in_hs ? SYNC_POL : ~SYNC_POL;
        vs_d  <= in_vs ? SYNC_POL : ~SYNC_POL;
        fs_d  <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {vga_r, vga_g, vga_b} <= 24'd0;
      vga_blank   <= 1'b1;
      vga_hsync   <= ~SYNC_POL;
      vga_vsync   <= ~SYNC_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= tick_d & fs_d;
      if (tick_d) begin
        {vga_r, vga_g, vga_b} <= pop_d ? fifo.fifo_dout : 24'd0;
        vga_blank <= ~pop_d;
        vga_hsync <= hs_d;
        vga_vsync <= vs_d;
      end
      if (starve) underflow <= 1'b1;
    end
  end
endmodule
